// File: rtl/ballot_pkg.sv
// Shared state type, default counter width and one-hot helper for the ballot controller.
package ballot_pkg;

   localparam int unsigned DefaultCntW = 16;
   localparam int unsigned MaxCand     = 32;

   typedef enum logic [1:0] {StIdle, StArmed, StLock, StResult} ballot_state_e;

   function automatic logic is_one_hot(input logic [MaxCand-1:0] vec);
      int unsigned ones;
      ones = 0;
      for (int i = 0; i < int'(MaxCand); i++) begin
         ones += 32'(vec[i]);
      end
      return ones == 1;
   endfunction

endpackage

// File: rtl/ballot_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; holds at all-ones.
module ballot_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/ballot_controller.sv
// One-ballot-per-arm voting sequencer with lockout, reject counting and result-mode freeze.
// Optional armed-ballot timeout is compiled in with `define BALLOT_TIMEOUT_EN.
module ballot_controller
   import ballot_pkg::*;
#(
   parameter int unsigned NUM_CAND       = 4,
   parameter int unsigned LOCK_CYCLES    = 100,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned CNT_W          = DefaultCntW
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                mode,
   input  logic                ballot_arm,
   input  logic [NUM_CAND-1:0] vote_valid,
   output logic [NUM_CAND-1:0] vote_commit,
   output logic                ballot_ready,
   output logic                vote_ack,
   output logic [CNT_W-1:0]    ballot_count,
   output logic [CNT_W-1:0]    reject_count,
   output logic                timeout_flag
);

   localparam int unsigned LockW = $clog2(LOCK_CYCLES + 1);

   ballot_state_e       state_q, state_d;
   logic [LockW-1:0]    lock_q, lock_d;
   logic [NUM_CAND-1:0] commit_q, commit_d;
   logic                inc_ballot, inc_reject;
   logic                press_any, press_one;
   logic                tmo_expire;

   assign press_any = |vote_valid;
   assign press_one = is_one_hot(MaxCand'(vote_valid));

   always_comb begin
      state_d    = state_q;
      lock_d     = lock_q;
      commit_d   = '0;
      inc_ballot = 1'b0;
      inc_reject = 1'b0;
      // Result mode overrides everything, including a same-cycle vote.
      if (mode) begin
         state_d = StResult;
      end else begin
         unique case (state_q)
            StIdle: begin
               inc_reject = press_any;
               if (ballot_arm) state_d = StArmed;
            end
            StArmed: begin
               if (press_one) begin
                  commit_d   = vote_valid;
                  inc_ballot = 1'b1;
                  lock_d     = LockW'(LOCK_CYCLES);
                  state_d    = StLock;
               end else begin
                  inc_reject = press_any;
                  if (tmo_expire) state_d = StIdle;
               end
            end
            StLock: begin
               inc_reject = press_any;
               if (lock_q == LockW'(1)) begin
                  state_d = StIdle;
               end else begin
                  lock_d = lock_q - LockW'(1);
               end
            end
            StResult: state_d = StIdle;
            default:  state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         lock_q   <= '0;
         commit_q <= '0;
      end else begin
         state_q  <= state_d;
         lock_q   <= lock_d;
         commit_q <= commit_d;
      end
   end

`ifdef BALLOT_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TmoW-1:0] tmo_q;
   logic            flag_q;

   // tmo_q counts armed cycles already spent; the last one is TIMEOUT_CYCLES-1.
   assign tmo_expire = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q  <= '0;
         flag_q <= 1'b0;
      end else if (!mode) begin
         if ((state_q == StIdle) && ballot_arm) begin
            tmo_q  <= '0;
            flag_q <= 1'b0;
         end else if ((state_q == StArmed) && !press_one) begin
            if (tmo_expire) begin
               flag_q <= 1'b1;
            end else begin
               tmo_q <= tmo_q + TmoW'(1);
            end
         end
      end
   end

   assign timeout_flag = flag_q;
`else
   logic unused_tmo;
   assign unused_tmo   = ^TIMEOUT_CYCLES;
   assign tmo_expire   = 1'b0;
   assign timeout_flag = 1'b0;
`endif

   ballot_sat_counter #(
      .CNT_W (CNT_W)
   ) u_ballot_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc_ballot),
      .count (ballot_count)
   );

   ballot_sat_counter #(
      .CNT_W (CNT_W)
   ) u_reject_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc_reject),
      .count (reject_count)
   );

   assign vote_commit  = commit_q;
   assign ballot_ready = (state_q == StArmed);
   assign vote_ack     = (state_q == StLock);

endmodule

// File: doc/ballot_controller.md
# ballot_controller

Sequences the voting datapath so that each voter casts exactly one ballot. It sits between the per-button conditioning outputs and the vote logger. A presiding officer arms one ballot at a time; the first clean single-candidate press is committed, and the machine then locks out further presses until the next arm. The block also counts committed and rejected presses and freezes voting while the machine is in result mode.

## Interface
- NUM_CAND, 4, number of candidates / vote_valid width
- LOCK_CYCLES, 100, cycles LOCK is held after a commit (≥1)
- TIMEOUT_CYCLES, 1000000, max cycles a ballot stays armed (≥1; used only with timeout compiled in)
- CNT_W, 16, width of ballot/reject counters
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; forces IDLE and clears all registers
- mode  in  1  0 = voting, 1 = result display
- ballot_arm  in  1  single-cycle pulse from officer button conditioning
- vote_valid  in  NUM_CAND  single-cycle press pulses from button conditioning
- vote_commit  out  NUM_CAND  registered one-hot, one-cycle pulse to vote logger
- ballot_ready  out  1  high while state = ARMED
- vote_ack  out  1  high while state = LOCK (LED feedback)
- ballot_count  out  CNT_W  committed ballots, saturating
- reject_count  out  CNT_W  rejected presses, saturating
- timeout_flag  out  1  sticky; armed ballot expired

## Operation
- States: IDLE, ARMED, LOCK, RESULT. Reset → IDLE; every output is 0.
- IDLE: ballot_arm=1 → ARMED; the timeout counter clears and timeout_flag clears.
- ARMED, vote_valid exactly one bit set → vote_commit = that bit for one cycle, ballot_count +1, → LOCK.
- ARMED, vote_valid two or more bits set → no commit, reject_count +1, stay ARMED.
- Any nonzero vote_valid in IDLE or LOCK → reject_count +1, no commit.
- ballot_arm in ARMED, LOCK or RESULT → ignored (ballots are not queued).
- IDLE with ballot_arm and vote_valid in the same cycle → arm accepted, press rejected and counted.
- LOCK: a down-counter loaded with LOCK_CYCLES. On expiry → IDLE.
- mode=1 in any state → RESULT at the next edge. An armed ballot is discarded without commit. vote_valid and ballot_arm are ignored and nothing is counted. mode=0 in RESULT → IDLE.
- mode takes priority over a vote in the same cycle: if mode=1 and vote_valid is one-hot while ARMED, there is no commit.
- Counters stop at all-ones and do not wrap. They are cleared only by reset.

## Timing
- Press sampled in cycle N (ARMED) → vote_commit high in cycle N+1 only. ballot_count updates and ballot_ready falls in N+1.
- vote_ack is high for exactly LOCK_CYCLES cycles starting at N+1. ballot_ready can rise no earlier than the cycle after the following ballot_arm.
- ballot_arm in cycle N → ballot_ready high from N+1.
- reject_count updates one cycle after the offending press.
- Reset is asserted asynchronously and must be deasserted synchronously upstream. If reset hits mid-LOCK, no pending commit is lost, because vote_commit has already been issued.

## Configuration
- BALLOT_TIMEOUT_EN defined: ARMED counts cycles. After TIMEOUT_CYCLES cycles with no commit → IDLE and timeout_flag=1. A press in the expiry cycle wins: it commits, and the flag is not set.
- Not defined: ARMED persists until a vote or mode=1. The timeout counter is not built, and timeout_flag is tied to 0.

## Structure
- Package ballot_pkg holds:
  - the state enum (IDLE, ARMED, LOCK, RESULT);
  - default CNT_W;
  - the one-hot check function (popcount == 1).
- One sub-module, ballot_sat_counter: a CNT_W-bit saturating incrementer with async active-low clear. It is instantiated twice, once for ballot_count and once for reject_count.

## Test plan
- Reset, then arm, then press vote_valid=4'b0010 → vote_commit=4'b0010 for 1 cycle, ballot_count=1, vote_ack high for 100 cycles, then IDLE.
- Arm, then press vote_valid=4'b0101 → no commit, reject_count=1, ballot_ready stays 1. A following 4'b0001 commits.
- Press 4'b1000 in IDLE and again during LOCK → reject_count +2 and no vote_commit pulses.
- Arm, then set mode=1 before any press → RESULT, ballot_ready=0, presses neither commit nor count. mode=0 → IDLE.
- With BALLOT_TIMEOUT_EN and TIMEOUT_CYCLES=20: arm and wait 20 cycles → IDLE, timeout_flag=1. The next arm clears the flag.
- Force ballot_count to all-ones minus one, then run two commits → count holds at all-ones.
